inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Instruction-fetch front end for the multi-cycle LoongArch core. Owns the PC,
//  drives the synchronous inst SRAM, and captures each returned word in a holding register.
//  Hands {pc, inst} to decode over a valid/ready handshake.
//  Accepts redirects (branch/jump targets) from decode/execute.
// PARAMETERS
//  RESET_PC  32'h1c000000  first fetch address after reset
//  SRAM_LAT  1             cycles from request to inst_sram_rdata valid; legal 1..4
// PORTS
//  clk               in   1   core clock
//  resetn            in   1   asynchronous, active-low reset
//  inst_sram_en      out  1   read request strobe, one cycle per fetch
//  inst_sram_we      out  1   constant 0
//  inst_sram_addr    out  32  fetch address (= pc)
//  inst_sram_wdata   out  32  constant 0
//  inst_sram_rdata   in   32  read data, valid SRAM_LAT cycles after en cycle
//  fs_valid          out  1   holding register carries an instruction for decode
//  ds_allowin        in   1   decode accepts; handshake = fs_valid & ds_allowin
//  fs_pc             out  32  pc of held instruction
//  fs_inst           out  32  held instruction word
//  fs_excp_adef      out  1   held entry is a misaligned-fetch exception
//  br_valid          in   1   redirect request, single-cycle pulse
//  br_target         in   32  redirect address
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE, pc=RESET_PC, wait_cnt=0. Outputs 0:
//  fs_valid, inst_sram_en, fs_pc, fs_inst, fs_excp_adef.
//  resetn deassertion arrives synchronised to clk from the top level.
//  States:
//   IDLE: en=0. Next state REQ unconditionally, one cycle after reset release.
//   REQ: en=1 and addr=pc, unless br_valid.
//    Next state WAIT with wait_cnt=SRAM_LAT.
//   WAIT: en=0. wait_cnt decrements each cycle.
//    When wait_cnt==1: capture rdata into fs_inst and pc into fs_pc; next state HOLD.
//   HOLD: fs_valid=1. fs_pc, fs_inst and fs_excp_adef are stable until handshake.
//    On handshake: pc<=pc+4 (mod 2^32 wrap), next state REQ, fs_valid drops next cycle.
//  Latency (SRAM_LAT=1): en in cycle t; rdata in t+1; fs_valid=1 in t+2.
//   Steady state, ds_allowin=1: one instruction per SRAM_LAT+2 cycles.
//  Redirect (br_valid=1) overrides in every non-IDLE state:
//   - pc<=br_target. Any in-flight read is abandoned; its rdata is never captured.
//   - An unaccepted held entry is dropped (fs_valid=0 next cycle).
//   - In REQ, en is forced 0 that cycle (combinational on br_valid).
//   - Aligned target (br_target[1:0]==0): next state REQ.
//   - Misaligned target: no SRAM request. Next state HOLD with fs_pc=br_target,
//     fs_inst=0, fs_excp_adef=1.
//   - Handshake and br_valid together in HOLD: the held instruction counts as
//     consumed, and the next fetch address is br_target, not pc+4.
//   - br_valid in IDLE is ignored.
//  fs_excp_adef is 0 for every SRAM-sourced entry.
//   It is cleared whenever a new SRAM word is captured.
//  Only one request is ever outstanding; en is never asserted outside REQ.
//  Reset mid-operation: all state is cleared immediately. The in-flight read is ignored.
//   Fetch restarts at RESET_PC via IDLE.
// TESTING
//  1 Release reset, SRAM_LAT=1, mem[0x1c000000]=0x02800421:
//    IDLE for 1 cycle; then en=1 with addr 0x1c000000.
//    2 cycles later: fs_valid=1, fs_inst=0x02800421, fs_pc=0x1c000000.
//  2 Hold ds_allowin=0 for 5 cycles in HOLD -> fs_pc/fs_inst stable, en stays 0.
//    Raise ds_allowin -> next en addr 0x1c000004.
//  3 br_valid with target 0x1c000100 during WAIT for 0x1c000008
//    -> old word never appears on fs_inst; next en addr 0x1c000100;
//    fs_pc=0x1c000100 on the next fs_valid.
//  4 br_valid with target 0x1c000102 -> no en pulse;
//    next cycle fs_valid=1, fs_excp_adef=1, fs_inst=0, fs_pc=0x1c000102.
//  5 Handshake with br_valid (target 0x1c000200) in the same cycle, HOLD
//    -> next en addr 0x1c000200, not pc+4.
//  6 SRAM_LAT=3: en-to-fs_valid = 4 cycles.
//    Pull resetn low mid-WAIT -> outputs 0 asynchronously; after release, refetch 0x1c000000.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one synchronous inst-SRAM read at a time,
// and presents the captured {pc, inst} to decode over a valid/ready handshake.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int unsigned SRAM_LAT = 1
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_sram_en,
    output logic        inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    output logic        fs_valid,
    input  logic        ds_allowin,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    output logic        fs_excp_adef,
    input  logic        br_valid,
    input  logic [31:0] br_target
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [2:0]  wait_cnt_q;
    logic [31:0] fs_pc_q;
    logic [31:0] fs_inst_q;
    logic        fs_excp_q;

    localparam logic [2:0] WaitInit = SRAM_LAT[2:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            wait_cnt_q <= 3'd0;
            fs_pc_q    <= 32'd0;
            fs_inst_q  <= 32'd0;
            fs_excp_q  <= 1'b0;
        end else if (state_q != StIdle && br_valid) begin
            // Redirect wins over everything: in-flight read and held entry are discarded.
            pc_q <= br_target;
            if (br_target[1:0] == 2'b00) begin
                state_q <= StReq;
            end else begin
                state_q   <= StHold;
                fs_pc_q   <= br_target;
                fs_inst_q <= 32'd0;
                fs_excp_q <= 1'b1;
            end
        end else begin
            unique case (state_q)
                StIdle: state_q <= StReq;
                StReq: begin
                    state_q    <= StWait;
                    wait_cnt_q <= WaitInit;
                end
                StWait: begin
                    wait_cnt_q <= wait_cnt_q - 3'd1;
                    if (wait_cnt_q == 3'd1) begin
                        state_q   <= StHold;
                        fs_pc_q   <= pc_q;
                        fs_inst_q <= inst_sram_rdata;
                        fs_excp_q <= 1'b0;
                    end
                end
                StHold: begin
                    if (ds_allowin) begin
                        state_q <= StReq;
                        pc_q    <= pc_q + 32'd4;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        inst_sram_en    = (state_q == StReq) && !br_valid;
        inst_sram_we    = 1'b0;
        inst_sram_addr  = pc_q;
        inst_sram_wdata = 32'd0;
        fs_valid        = (state_q == StHold);
        fs_pc           = fs_pc_q;
        fs_inst         = fs_inst_q;
        fs_excp_adef    = fs_excp_q;
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: one instance with SRAM_LAT=1 and one with SRAM_LAT=3,
// each with its own SRAM model, request scoreboard and response scoreboard.
module tb_inst_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        a_resetn, a_en, a_we, a_fs_valid, a_ds_allowin, a_adef, a_br_valid;
    logic [31:0] a_addr, a_wdata, a_rdata, a_fs_pc, a_fs_inst, a_br_target;
    logic        b_resetn, b_en, b_we, b_fs_valid, b_ds_allowin, b_adef, b_br_valid;
    logic [31:0] b_addr, b_wdata, b_rdata, b_fs_pc, b_fs_inst, b_br_target;

    logic [31:0] a_req_q[$];
    logic [31:0] b_req_q[$];
    resp_t       a_resp_q[$];
    resp_t       b_resp_q[$];

    inst_fetch_unit #(.RESET_PC(32'h1c000000), .SRAM_LAT(1)) u_dut_a (
        .clk(clk), .resetn(a_resetn),
        .inst_sram_en(a_en), .inst_sram_we(a_we), .inst_sram_addr(a_addr),
        .inst_sram_wdata(a_wdata), .inst_sram_rdata(a_rdata),
        .fs_valid(a_fs_valid), .ds_allowin(a_ds_allowin), .fs_pc(a_fs_pc),
        .fs_inst(a_fs_inst), .fs_excp_adef(a_adef),
        .br_valid(a_br_valid), .br_target(a_br_target)
    );

    inst_fetch_unit #(.RESET_PC(32'h1c000000), .SRAM_LAT(3)) u_dut_b (
        .clk(clk), .resetn(b_resetn),
        .inst_sram_en(b_en), .inst_sram_we(b_we), .inst_sram_addr(b_addr),
        .inst_sram_wdata(b_wdata), .inst_sram_rdata(b_rdata),
        .fs_valid(b_fs_valid), .ds_allowin(b_ds_allowin), .fs_pc(b_fs_pc),
        .fs_inst(b_fs_inst), .fs_excp_adef(b_adef),
        .br_valid(b_br_valid), .br_target(b_br_target)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h1c000000) return 32'h02800421;
        return {a[15:0], ~a[31:16]};
    endfunction

    // SRAM models; cycles without a request return a poison word.
    always @(posedge clk) a_rdata <= a_en ? mem_word(a_addr) : 32'hDEADBEEF;

    logic [31:0] b_pipe [3];
    always @(posedge clk) begin
        b_pipe[0] <= b_en ? mem_word(b_addr) : 32'hDEADBEEF;
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign b_rdata = b_pipe[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %h expected no event at %0t", name, act, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors
    always @(negedge clk) begin
        resp_t r;
        if (a_resetn === 1'b1 && a_en) begin
            if (a_req_q.size() == 0) unexpected("a_req_addr", a_addr);
            else check("a_req_addr", a_addr, a_req_q.pop_front());
            check("a_we", 32'(a_we), 32'd0);
            check("a_wdata", a_wdata, 32'd0);
        end
        if (a_resetn === 1'b1 && a_fs_valid && a_ds_allowin) begin
            if (a_resp_q.size() == 0) unexpected("a_resp_pc", a_fs_pc);
            else begin
                r = a_resp_q.pop_front();
                check("a_resp_pc", a_fs_pc, r.pc);
                check("a_resp_inst", a_fs_inst, r.inst);
                check("a_resp_adef", 32'(a_adef), 32'(r.adef));
            end
        end
        if (b_resetn === 1'b1 && b_en) begin
            if (b_req_q.size() == 0) unexpected("b_req_addr", b_addr);
            else check("b_req_addr", b_addr, b_req_q.pop_front());
        end
        if (b_resetn === 1'b1 && b_fs_valid && b_ds_allowin) begin
            if (b_resp_q.size() == 0) unexpected("b_resp_pc", b_fs_pc);
            else begin
                r = b_resp_q.pop_front();
                check("b_resp_pc", b_fs_pc, r.pc);
                check("b_resp_inst", b_fs_inst, r.inst);
                check("b_resp_adef", 32'(b_adef), 32'(r.adef));
            end
        end
    end

    task automatic measure_b_latency(output int lat);
        bit seen;
        lat  = -1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (b_en) seen = 1'b1;
        end
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            @(negedge clk);
            if (b_fs_valid) lat = k;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        a_resetn = 1'b1; a_ds_allowin = 1'b0; a_br_valid = 1'b0; a_br_target = 32'd0;
        b_resetn = 1'b1; b_ds_allowin = 1'b0; b_br_valid = 1'b0; b_br_target = 32'd0;
        #1;
        a_resetn = 1'b0;
        b_resetn = 1'b0;

        a_req_q  = '{32'h1c000000, 32'h1c000004, 32'h1c000008, 32'h1c000100,
                     32'h1c000200, 32'h1c000300};
        a_resp_q = '{'{32'h1c000000, 32'h02800421, 1'b0},
                     '{32'h1c000004, 32'h0004e3ff, 1'b0},
                     '{32'h1c000100, 32'h0100e3ff, 1'b0},
                     '{32'h1c000102, 32'h00000000, 1'b1},
                     '{32'h1c000200, 32'h0200e3ff, 1'b0}};
        b_req_q  = '{32'h1c000000, 32'h1c000004, 32'h1c000000, 32'h1c000004};
        b_resp_q = '{'{32'h1c000000, 32'h02800421, 1'b0},
                     '{32'h1c000000, 32'h02800421, 1'b0}};

        // ---- Instance A (SRAM_LAT=1) ----
        repeat (2) @(negedge clk);
        check("a_rst_en", 32'(a_en), 32'd0);
        check("a_rst_valid", 32'(a_fs_valid), 32'd0);
        check("a_rst_pc", a_fs_pc, 32'd0);
        check("a_rst_inst", a_fs_inst, 32'd0);
        check("a_rst_adef", 32'(a_adef), 32'd0);

        step(); a_resetn = 1'b1;            // IDLE
        @(negedge clk);
        check("a_idle_en", 32'(a_en), 32'd0);
        step();                             // REQ 1c000000
        step();                             // WAIT
        step();                             // HOLD, stalled for 5 cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("a_stall_valid", 32'(a_fs_valid), 32'd1);
            check("a_stall_pc", a_fs_pc, 32'h1c000000);
            check("a_stall_inst", a_fs_inst, 32'h02800421);
            check("a_stall_en", 32'(a_en), 32'd0);
            step();
        end
        a_ds_allowin = 1'b1;                // handshake
        step();                             // REQ 1c000004
        step();                             // WAIT
        step();                             // HOLD, accepted
        step();                             // REQ 1c000008
        step();                             // WAIT: redirect aligned
        a_br_valid = 1'b1; a_br_target = 32'h1c000100;
        step(); a_br_valid = 1'b0;          // REQ 1c000100
        step();                             // WAIT
        step();                             // HOLD, accepted
        step();                             // REQ: misaligned redirect suppresses en
        a_br_valid = 1'b1; a_br_target = 32'h1c000102;
        step();                             // HOLD adef: handshake + redirect
        a_br_target = 32'h1c000200;
        step(); a_br_valid = 1'b0;          // REQ 1c000200
        step();                             // WAIT
        step();                             // HOLD: handshake + redirect
        a_br_valid = 1'b1; a_br_target = 32'h1c000300;
        step(); a_br_valid = 1'b0;          // REQ 1c000300
        step(); a_ds_allowin = 1'b0;        // WAIT
        repeat (4) step();
        @(negedge clk);
        check("a_final_valid", 32'(a_fs_valid), 32'd1);
        check("a_final_pc", a_fs_pc, 32'h1c000300);
        check("a_final_inst", a_fs_inst, 32'h0300e3ff);
        check("a_final_adef", 32'(a_adef), 32'd0);

        // ---- Instance B (SRAM_LAT=3) ----
        step(); b_resetn = 1'b1;
        measure_b_latency(lat);
        check("b_latency", 32'(lat), 32'd4);
        step(); b_ds_allowin = 1'b1;        // handshake
        step(); b_ds_allowin = 1'b0;        // REQ 1c000004
        step();                             // WAIT
        step();                             // WAIT
        #2 b_resetn = 1'b0;
        #1;
        check("b_async_en", 32'(b_en), 32'd0);
        check("b_async_valid", 32'(b_fs_valid), 32'd0);
        check("b_async_pc", b_fs_pc, 32'd0);
        check("b_async_inst", b_fs_inst, 32'd0);
        check("b_async_adef", 32'(b_adef), 32'd0);
        step();
        step(); b_resetn = 1'b1;
        measure_b_latency(lat);
        check("b_relatency", 32'(lat), 32'd4);
        step(); b_ds_allowin = 1'b1;
        step(); b_ds_allowin = 1'b0;        // REQ 1c000004
        repeat (6) step();
        @(negedge clk);
        check("b_final_valid", 32'(b_fs_valid), 32'd1);
        check("b_final_pc", b_fs_pc, 32'h1c000004);

        check("a_req_left", 32'(a_req_q.size()), 32'd0);
        check("a_resp_left", 32'(a_resp_q.size()), 32'd0);
        check("b_req_left", 32'(b_req_q.size()), 32'd0);
        check("b_resp_left", 32'(b_resp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
